// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_scanner_pkg
//   Shared definitions for the 4-digit seven-segment scanner: scan-state
//   encodings, all-off constants for anodes and segments, the 16 active-low
//   hex glyph patterns ({g,f,e,d,c,b,a}), and a one-hot-low anode helper.
package seven_seg_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Active-low one-hot anode enable for the given digit position.
  function automatic logic [3:0] anode_sel(input logic [1:0] digit);
    anode_sel = ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Bundle between a display-value producer and the scanner.
//   Producer -> scanner: enable, data_clk (divider tap bus), value (4 hex
//   nibbles, [3:0] = rightmost digit), dp_in (1 = lit), blank (1 = dark).
//   Scanner -> board: an (anodes, active-low), seg ({g..a}, active-low),
//   dp (decimal point, active-low).
//   master = producer/board side, slave = scanner.
interface seven_seg_scanner_if;
  logic        enable;
  logic [15:0] data_clk;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output enable, data_clk, value, dp_in, blank,
    input  an, seg, dp
  );

  modport slave (
    input  enable, data_clk, value, dp_in, blank,
    output an, seg, dp
  );
endinterface

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// hex_to_7seg
//   Combinational hex digit to active-low seven-segment glyph decoder,
//   shared by the display blocks.
//   hex : in  4  nibble to display
//   seg : out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_7seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Glyph lookup.
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      4'hF:    seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes a 16-bit hex value onto a 4-digit common-anode display.
//   A rising edge of data_clk[TAP_SEL] advances the scan; every digit change
//   is preceded by BLANK_CYCLES clocks of all-anodes-off to avoid ghosting.
//   value/dp_in/blank are snapshotted once per frame (at digit 0) so a frame
//   never mixes old and new data.
//   clk   : in  system clock (same domain as the divider)
//   reset : in  asynchronous, active-low
//   bus   : slave side of seven_seg_scanner_if (inputs + registered an/seg/dp)
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int TAP_SEL      = 15,
  parameter int BLANK_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  seven_seg_scanner_if.slave bus
);

  localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYCLES - 1);

  scan_state_e state_r, state_nxt_s;
  logic        tap_r;
  logic        tick_s;
  logic [1:0]  digit_r, digit_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [15:0] val_snap_r, val_nxt_s;
  logic [3:0]  dp_snap_r, dp_snap_nxt_s;
  logic [3:0]  blank_snap_r, blank_nxt_s;
  logic [3:0]  an_r, an_nxt_s;
  logic [6:0]  seg_r, seg_nxt_s;
  logic        dp_r, dp_nxt_s;
  logic [3:0]  nibble_s;
  logic [6:0]  pattern_s;
  logic        unused_taps_s;

  // Only one tap is consumed; the rest of the bus is folded away here.
  assign unused_taps_s = ^bus.data_clk;

  assign tick_s = bus.data_clk[TAP_SEL] & ~tap_r;

  // Next scan state, digit, blanking counter and frame snapshot.
  always_comb begin
    state_nxt_s   = state_r;
    digit_nxt_s   = digit_r;
    cnt_nxt_s     = cnt_r;
    val_nxt_s     = val_snap_r;
    dp_snap_nxt_s = dp_snap_r;
    blank_nxt_s   = blank_snap_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.enable && tick_s) begin
          state_nxt_s   = ST_BLANK;
          digit_nxt_s   = 2'd0;
          cnt_nxt_s     = CNT_LOAD;
          val_nxt_s     = bus.value;
          dp_snap_nxt_s = bus.dp_in;
          blank_nxt_s   = bus.blank;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BLANK: begin
        // Ticks are deliberately ignored here; the gap always runs to length.
        if (!bus.enable) begin
          state_nxt_s = ST_IDLE;
          digit_nxt_s = 2'd0;
          cnt_nxt_s   = 8'd0;
        end else if (cnt_r == 8'd0) begin
          state_nxt_s = ST_DRIVE;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      ST_DRIVE: begin
        if (!bus.enable) begin
          state_nxt_s = ST_IDLE;
          digit_nxt_s = 2'd0;
          cnt_nxt_s   = 8'd0;
        end else if (tick_s) begin
          state_nxt_s = ST_BLANK;
          digit_nxt_s = digit_r + 2'd1;
          cnt_nxt_s   = CNT_LOAD;
          // Wrapping back to digit 0 starts a new frame: take a fresh snapshot.
          if (digit_r == 2'd3) begin
            val_nxt_s     = bus.value;
            dp_snap_nxt_s = bus.dp_in;
            blank_nxt_s   = bus.blank;
          end else begin
            val_nxt_s = val_snap_r;
          end
        end else begin
          state_nxt_s = ST_DRIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        digit_nxt_s = 2'd0;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  assign nibble_s = val_nxt_s[{digit_nxt_s, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .hex (nibble_s),
    .seg (pattern_s)
  );

  // Next anode/segment/dp drive.
  always_comb begin
    an_nxt_s  = ANODE_OFF;
    seg_nxt_s = SEG_OFF;
    dp_nxt_s  = 1'b1;
    case (state_nxt_s)
      ST_BLANK: begin
        // Segments settle on the upcoming glyph while the anodes are off.
        an_nxt_s  = ANODE_OFF;
        seg_nxt_s = pattern_s;
        dp_nxt_s  = ~dp_snap_nxt_s[digit_nxt_s];
      end
      ST_DRIVE: begin
        if (blank_nxt_s[digit_nxt_s]) begin
          an_nxt_s  = ANODE_OFF;
          seg_nxt_s = SEG_OFF;
          dp_nxt_s  = 1'b1;
        end else begin
          an_nxt_s  = anode_sel(digit_nxt_s);
          seg_nxt_s = pattern_s;
          dp_nxt_s  = ~dp_snap_nxt_s[digit_nxt_s];
        end
      end
      default: begin
        an_nxt_s  = ANODE_OFF;
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = 1'b1;
      end
    endcase
  end

  // Scan FSM state, snapshot and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      tap_r        <= 1'b0;
      digit_r      <= 2'd0;
      cnt_r        <= 8'd0;
      val_snap_r   <= 16'h0000;
      dp_snap_r    <= 4'h0;
      blank_snap_r <= 4'h0;
      an_r         <= ANODE_OFF;
      seg_r        <= SEG_OFF;
      dp_r         <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      tap_r        <= bus.data_clk[TAP_SEL];
      digit_r      <= digit_nxt_s;
      cnt_r        <= cnt_nxt_s;
      val_snap_r   <= val_nxt_s;
      dp_snap_r    <= dp_snap_nxt_s;
      blank_snap_r <= blank_nxt_s;
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      dp_r         <= dp_nxt_s;
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;
  assign bus.dp  = dp_r;

endmodule
